// File: rtl/fpga_robots_game_serial_rx.sv
// ---------------------------------------------------------------------------
// fpga_robots_game_serial_rx
//
// UART receiver for the game's serial console port. The frame format is 8N1,
// LSB first, and the line is oversampled 8x using the baud8 tick from the
// clock block. A received byte goes into a one-entry holding register and is
// offered on a valid/ready handshake. Overrun and framing errors are reported
// as single-cycle pulses.
//
// Ports
//   clk          in   system clock (~65 MHz)
//   rst_n        in   synchronous active-low reset
//   baud8        in   single-cycle oversample tick (8 per bit time)
//   rxd          in   raw serial line, asynchronous, idle high
//   rx_data      out  received byte, stable while rx_valid is high
//   rx_valid     out  holding register full
//   rx_ready     in   consumer ready
//   rx_overrun   out  pulse: complete byte dropped, holding register was full
//   rx_frame_err out  pulse: stop bit sampled low
//   rx_busy      out  receiver FSM not idle
//   fsm_state    out  current FSM state encoding (debug visibility)
//
// Handshake: a byte transfers on every rising clk edge where rx_valid and
// rx_ready are both 1. rx_valid never drops without a transfer, and rx_data
// does not change while rx_valid is high unless a transfer happens on that
// same edge. rx_ready is ignored while rx_valid is 0.
// ---------------------------------------------------------------------------
module fpga_robots_game_serial_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud8,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] tickctr;
  logic [2:0] tickctr_nxt;
  logic [2:0] bitctr;
  logic [2:0] bitctr_nxt;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;

  logic       sync1;
  logic       rxs;

  // Strobes from the FSM, valid only in the stop-sample tick cycle.
  logic       deliver;
  logic       frame_err;
  logic       accept;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. Resets to the idle level so a reset never looks
  // like a start bit.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM state and counters.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tickctr <= 3'd0;
      bitctr  <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      state   <= state_nxt;
      tickctr <= tickctr_nxt;
      bitctr  <= bitctr_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Nothing moves unless baud8 is high, so with baud8
  // held low the receiver is frozen in place.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    tickctr_nxt = tickctr;
    bitctr_nxt  = bitctr;
    shreg_nxt   = shreg;
    deliver     = 1'b0;
    frame_err   = 1'b0;

    if (baud8) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_nxt   = START;
            tickctr_nxt = 3'd0;
          end
        end

        START: begin
          // Fourth tick after detection lands near the middle of the start
          // bit; a line that is already high again was only a glitch.
          if (tickctr == 3'd3) begin
            tickctr_nxt = 3'd0;
            if (!rxs) begin
              state_nxt  = DATA;
              bitctr_nxt = 3'd0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tickctr_nxt = tickctr + 3'd1;
          end
        end

        DATA: begin
          if (tickctr == 3'd7) begin
            // LSB arrives first, so shifting in at the MSB leaves bit 0 in
            // place after the eighth sample.
            shreg_nxt   = {rxs, shreg[7:1]};
            tickctr_nxt = 3'd0;
            if (bitctr == 3'd7) begin
              state_nxt = STOP;
            end else begin
              bitctr_nxt = bitctr + 3'd1;
            end
          end else begin
            tickctr_nxt = tickctr + 3'd1;
          end
        end

        STOP: begin
          if (tickctr == 3'd7) begin
            tickctr_nxt = 3'd0;
            if (rxs) begin
              deliver   = 1'b1;
              state_nxt = IDLE;
            end else begin
              frame_err = 1'b1;
              state_nxt = WAIT_IDLE;
            end
          end else begin
            tickctr_nxt = tickctr + 3'd1;
          end
        end

        WAIT_IDLE: begin
          // A line held low (break) must return high before the next start
          // can be recognised.
          if (rxs) begin
            state_nxt = IDLE;
          end
        end

        default: begin
          state_nxt   = IDLE;
          tickctr_nxt = 3'd0;
          bitctr_nxt  = 3'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Holding register and error pulses.
  // -------------------------------------------------------------------------
  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= frame_err;
      if (deliver) begin
        // The register is free if empty or being drained on this same edge.
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy   = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_fpga_robots_game_serial_rx.sv
`timescale 1ns/1ps
module tb_fpga_robots_game_serial_rx;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud8;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_busy;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  fpga_robots_game_serial_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud8        (baud8),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
    .fsm_state    (fsm_state)
  );

  // baud8: one tick every 4 clocks while enabled, changed on the falling edge.
  bit tick_en = 1'b1;
  int div = 0;
  initial begin
    baud8 = 1'b0;
    forever begin
      @(negedge clk);
      baud8 = tick_en && (div == 0);
      div = (div + 1) % 4;
    end
  end

  int tick_cnt = 0;
  always @(posedge clk) if (baud8) tick_cnt <= tick_cnt + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int valid_cyc = 0;
  int ovr_cnt   = 0;
  int fe_cnt    = 0;
  logic prev_valid = 1'b0;
  logic prev_busy  = 1'b0;
  logic rise_busy  = 1'bx;
  logic rise_prev_busy = 1'bx;

  // One clock step: sample outputs and inputs just before the coming rising
  // edge, score any handshake, then advance to the next falling edge.
  task automatic cycle();
    logic [7:0] e;
    #3;
    if (rx_valid) valid_cyc++;
    if (rx_overrun) ovr_cnt++;
    if (rx_frame_err) fe_cnt++;
    if (rx_valid && !prev_valid) begin
      rise_busy      = rx_busy;
      rise_prev_busy = prev_busy;
    end
    prev_valid = rx_valid;
    prev_busy  = rx_busy;
    if (rst_n && rx_valid && rx_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got %02h, queue empty", rx_data);
      end else begin
        e = exp_q.pop_front();
        if (rx_data !== e) $display("FAIL sb_data: got %02h, expected %02h", rx_data, e);
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = tick_cnt + n;
    guard = 0;
    while (tick_cnt < target && guard < n * 8 + 400) begin
      cycle();
      guard++;
    end
    if (tick_cnt < target) begin
      n_checks++;
      $display("FAIL tick_timeout: got %0d ticks, expected %0d", tick_cnt, target);
    end
  endtask

  // ---------------- driver ----------------
  // Start bit, 8 data bits LSB first, stop bit; 8 ticks each. rxd is left at
  // the stop level.
  task automatic send_bits(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    wait_ticks(8);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_ticks(8);
    end
    rxd = stop;
    wait_ticks(8);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %02h, expected %02h", name, got, exp);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", {7'd0, rx_valid}, 8'h00);
    chk("reset_overrun", {7'd0, rx_overrun}, 8'h00);
    chk("reset_frame_err", {7'd0, rx_frame_err}, 8'h00);
    chk("reset_busy", {7'd0, rx_busy}, 8'h00);
  endtask

  task automatic test_single_byte();
    int v0, o0, f0;
    v0 = valid_cyc; o0 = ovr_cnt; f0 = fe_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    send_bits(8'h55, 1'b1);
    wait_ticks(4);
    chk("single_valid_cycles", 8'(valid_cyc - v0), 8'd1);
    chk("single_delivered", 8'(exp_q.size()), 8'd0);
    chk("single_busy_at_rise", {7'd0, rise_busy}, 8'h00);
    chk("single_busy_before_rise", {7'd0, rise_prev_busy}, 8'h01);
    chk("single_no_overrun", 8'(ovr_cnt - o0), 8'd0);
    chk("single_no_frame_err", 8'(fe_cnt - f0), 8'd0);
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cyc; f0 = fe_cnt;
    rxd = 1'b0;
    wait_ticks(2);
    chk("glitch_busy", {7'd0, rx_busy}, 8'h01);
    rxd = 1'b1;
    wait_ticks(8);
    chk("glitch_idle", {5'd0, fsm_state}, {5'd0, S_IDLE});
    chk("glitch_no_valid", 8'(valid_cyc - v0), 8'd0);
    chk("glitch_no_frame_err", 8'(fe_cnt - f0), 8'd0);
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_cyc; f0 = fe_cnt;
    send_bits(8'hA5, 1'b0);
    wait_ticks(20);
    chk("ferr_wait_idle", {5'd0, fsm_state}, {5'd0, S_WAIT_IDLE});
    chk("ferr_pulse_count", 8'(fe_cnt - f0), 8'd1);
    chk("ferr_no_valid", 8'(valid_cyc - v0), 8'd0);
    rxd = 1'b1;
    wait_ticks(3);
    chk("ferr_back_idle", {5'd0, fsm_state}, {5'd0, S_IDLE});
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 1'b1);
    wait_ticks(2);
    chk("ferr_next_byte", 8'(exp_q.size()), 8'd0);
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_bits(8'h11, 1'b1);
    send_bits(8'h22, 1'b1);
    wait_ticks(2);
    chk("ovr_valid", {7'd0, rx_valid}, 8'h01);
    chk("ovr_data_kept", rx_data, 8'h11);
    chk("ovr_pulse_count", 8'(ovr_cnt - o0), 8'd1);
    rx_ready = 1'b1;
    cycle();
    chk("ovr_valid_cleared", {7'd0, rx_valid}, 8'h00);
    chk("ovr_data_after_accept", rx_data, 8'h11);
    rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back_accept();
    int o0, t, k;
    bit timed_out;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_bits(8'h11, 1'b1);
    o0 = ovr_cnt;
    exp_q.push_back(8'h22);
    timed_out = 1'b0;
    fork
      send_bits(8'h22, 1'b1);
      begin
        k = 0;
        do begin @(negedge clk); #1; k++; end while (fsm_state !== S_STOP && k < 3000);
        if (k >= 3000) timed_out = 1'b1;
        t = tick_cnt;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!(baud8 && tick_cnt == t + 7) && k < 200);
        if (k >= 200) timed_out = 1'b1;
        rx_ready = 1'b1;
        @(negedge clk); #1;
        rx_ready = 1'b0;
      end
    join
    chk("sim_no_timeout", {7'd0, timed_out}, 8'h00);
    chk("sim_valid_held", {7'd0, rx_valid}, 8'h01);
    chk("sim_new_data", rx_data, 8'h22);
    chk("sim_no_overrun", 8'(ovr_cnt - o0), 8'd0);
    rx_ready = 1'b1;
    cycle();
    cycle();
    chk("sim_drained", 8'(exp_q.size()), 8'd0);
  endtask

  task automatic test_freeze();
    int t0;
    rx_ready = 1'b1;
    exp_q.push_back(8'h96);
    t0 = tick_cnt;
    fork
      send_bits(8'h96, 1'b1);
      begin
        while (tick_cnt < t0 + 20) begin @(negedge clk); #1; end
        tick_en = 1'b0;
        @(negedge clk); #1;
        chk("freeze_in_data", {5'd0, fsm_state}, {5'd0, S_DATA});
        repeat (40) @(negedge clk);
        #1;
        chk("freeze_still_data", {5'd0, fsm_state}, {5'd0, S_DATA});
        tick_en = 1'b1;
      end
    join
    wait_ticks(2);
    chk("freeze_byte_ok", 8'(exp_q.size()), 8'd0);
  endtask

  task automatic test_reset_mid_frame();
    int t0, f0, o0;
    rx_ready = 1'b0;
    send_bits(8'h5A, 1'b1);
    wait_ticks(2);
    chk("rmf_held_valid", {7'd0, rx_valid}, 8'h01);
    t0 = tick_cnt;
    fork
      send_bits(8'hF8, 1'b1);
      begin
        while (tick_cnt < t0 + 36) begin @(negedge clk); #1; end
        chk("rmf_in_data", {5'd0, fsm_state}, {5'd0, S_DATA});
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        chk("rmf_data", rx_data, 8'h00);
        chk("rmf_valid", {7'd0, rx_valid}, 8'h00);
        chk("rmf_busy", {7'd0, rx_busy}, 8'h00);
        chk("rmf_errs", {6'd0, rx_overrun, rx_frame_err}, 8'h00);
      end
    join
    wait_ticks(4);
    f0 = fe_cnt; o0 = ovr_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 1'b1);
    wait_ticks(2);
    chk("rmf_next_byte", 8'(exp_q.size()), 8'd0);
    chk("rmf_no_errs", 8'((fe_cnt - f0) + (ovr_cnt - o0)), 8'd0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_bits(b, 1'b1);
    end
    wait_ticks(2);
    chk("b2b_all_delivered", 8'(exp_q.size()), 8'd0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back_accept();
    test_freeze();
    test_reset_mid_frame();
    test_back_to_back();
    chk("final_queue_empty", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpga_robots_game_serial_rx.md
# fpga_robots_game_serial_rx

UART receiver for the game's serial console port: 8N1 framing at 115,200 baud, oversampled 8× using the `baud8` timing pulse from the clock block. It sits between the board's RX pin and the command/input logic. Each received byte is presented on a valid/ready handshake with a one-entry holding register, and overrun and framing errors are flagged.

## Interface
- No parameters. Frame format fixed 8N1, LSB first; oversample ratio fixed at 8.
- `clk`  in  1  system clock, ~65 MHz.
- `rst_n`  in  1  reset, synchronous, active-low.
- `baud8`  in  1  single-cycle pulse, 921,600/s; one "tick".
- `rxd`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `rx_data`  out  8  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts when `rx_valid`&&`rx_ready` at a `clk` edge.
- `rx_overrun`  out  1  one-cycle pulse: complete byte dropped, holding register full.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_busy`  out  1  state != IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1); the output is `rxs`. All line decisions use `rxs`, and only in cycles where `baud8`=1. States change only on ticks.
- Counters: `tickctr` 3 bits, `bitctr` 3 bits, shift register 8 bits.
- IDLE: tick with `rxs`=0 → START, `tickctr`←0.
- START: on each tick, if `tickctr`==3 (4th tick after detection, ≈ mid start bit):
  - `rxs`=0 → DATA, `tickctr`←0, `bitctr`←0.
  - `rxs`=1 → IDLE (glitch rejected, no flag).
  - Otherwise `tickctr`++.
- DATA: on each tick, if `tickctr`==7: shift `rxs` in at MSB (LSB-first reception), `tickctr`←0; if `bitctr`==7 → STOP, else `bitctr`++. Otherwise `tickctr`++.
- STOP: on a tick with `tickctr`==7:
  - `rxs`=1 → deliver byte, → IDLE.
  - `rxs`=0 → pulse `rx_frame_err`, discard byte, → WAIT_IDLE.
  - Otherwise `tickctr`++.
- WAIT_IDLE (break/line-low recovery): tick with `rxs`=1 → IDLE. No new start is detected until then.
- Deliver:
  - Holding register empty, or being accepted in the same cycle: `rx_data`←byte, `rx_valid`←1.
  - Full and not accepted: byte dropped, `rx_data` unchanged, `rx_overrun` pulses.
- Accept without a delivery in the same cycle: `rx_valid`←0 next edge; `rx_data` keeps its last value.

## Timing
- Reset (`rst_n`=0 at a `clk` edge): state IDLE; counters 0; synchronizer 1.
- Outputs after reset: `rx_data`=0x00; `rx_valid`, `rx_overrun`, `rx_frame_err`, `rx_busy` all 0.
- Reset mid-frame abandons the frame silently; any held byte is lost.
- Synchronizer latency: 2 `clk` cycles from `rxd` to `rxs`.
- Sample points: data bit k at tick 4+8(k+1) after the detection tick; stop bit at tick 4+72=76.
- `rx_valid` rises, and `rx_overrun` / `rx_frame_err` pulse, on the edge after the stop-sample tick. Pulses are exactly 1 cycle wide.
- Simultaneous delivery and accept: `rx_valid` stays 1, `rx_data` takes the new byte, no overrun.
- `rx_ready` while `rx_valid`=0: ignored.
- `baud8` held 0: FSM frozen; handshake still operates.
- `baud8` high on consecutive cycles: each high cycle counts as a tick. The bench treats this as out of spec, but it must not hang the FSM.

## Test plan
- Send 0x55, 8 ticks/bit, `rx_ready`=1 → `rx_valid` high exactly 1 cycle with `rx_data`=0x55; `rx_busy` drops the same edge; no error pulses.
- `rxd` low for 2 ticks only, then high → returns to IDLE from START; no `rx_valid`, no `rx_frame_err`.
- Send 0xA5 with stop bit low, hold low 20 ticks, then idle → one `rx_frame_err` pulse, no `rx_valid`, stays WAIT_IDLE until high. A following 0x3C is received correctly.
- `rx_ready`=0; send 0x11 then 0x22 → `rx_data`=0x11 retained, one `rx_overrun` pulse at the second byte's stop. Raising `rx_ready` clears `rx_valid` next edge.
- Hold 0x11, assert `rx_ready` exactly in the 0x22 delivery cycle → `rx_valid` stays 1, `rx_data`=0x22, no `rx_overrun`.
- Pulse `rst_n` low during DATA bit 3 → all outputs at reset values next edge. Next full byte 0xC3 is received correctly with no error pulses.
